hazard_sequencer: RTL and testbench
===================================

// Module: hazard_sequencer
// PURPOSE
//  Pipeline sequencer for the 5-stage core. Sits beside the decode-stage control decoder and
//  consumes its outputs (REG_WRITE, MEM_READ, halt) plus the register specifiers.
//  Tracks in-flight writers in a shadow EX/MEM/WB pipe and drives PC/IF-ID enables,
//  ID/EX bubble insertion, flush on redirect, freeze on a data-memory stall, and halt drain.
// PARAMETERS
//  REG_ADDR_W  3   register specifier width
//  FORWARDING  1   1: stall only on load-use; 0: stall on any RAW against an EX or MEM writer
//  CNT_W       16  stall_count width
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           synchronous reset, ACTIVE-LOW
//  id_valid      in   1           ID holds a real instruction (not NOP/squashed)
//  id_rs         in   REG_ADDR_W  source register 1
//  id_rs_use     in   1           instruction reads id_rs
//  id_rt         in   REG_ADDR_W  source register 2
//  id_rt_use     in   1           instruction reads id_rt
//  id_reg_write  in   1           decoder REG_WRITE
//  id_wr_reg     in   REG_ADDR_W  destination register
//  id_mem_read   in   1           decoder MEM_READ (load)
//  id_halt       in   1           instruction in ID is HALT
//  ex_redirect   in   1           branch taken / jump / JR resolved in EX this cycle
//  mem_busy      in   1           data memory not ready; MEM stage must hold
//  pc_en         out  1           PC may update
//  ifid_en       out  1           IF/ID register may load
//  ifid_flush    out  1           IF/ID loads a NOP
//  idex_bubble   out  1           ID/EX loads a NOP
//  pipe_freeze   out  1           hold EX/MEM/WB registers
//  halted        out  1           core halted, pipe empty
//  stall_count   out  CNT_W       cycles with pc_en=0 while RUN (saturating)
// BEHAVIOUR
//  State FSM: RUN, DRAIN, HALTED. Reset (rst=0 at clk edge) -> RUN, shadow pipe cleared, count=0.
//  While rst=0 the outputs are forced to: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1,
//   pipe_freeze=0, halted=0.
//  Shadow pipe: stages ex/mem/wb each hold {valid, wr, rd, ld}. It advances on each edge unless
//   frozen. ex receives ID info when ID advances, and a bubble (valid=0) otherwise.
//  Hazard (combinational, only when id_valid): a source register matches when
//   (id_rs_use & rs==X.rd) | (id_rt_use & rt==X.rd), for stage X valid and X.wr.
//   FORWARDING=1: hazard = match on ex with ex.ld=1. FORWARDING=0: hazard = match on ex or mem.
//   WB never causes a hazard (register file writes through). Register 0 is not special.
//  RUN priority, highest first, same cycle:
//   1 mem_busy: pipe_freeze=1, pc_en=0, ifid_en=0, no flush, no bubble, shadow holds.
//     A concurrent ex_redirect is held by the datapath and is acted on the first non-busy cycle.
//   2 ex_redirect: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1. A hazard or halt in ID is squashed.
//   3 hazard: pc_en=0, ifid_en=0, idex_bubble=1.
//   4 id_valid & id_halt: the HALT enters EX, pc_en=0, ifid_en=0 -> DRAIN next cycle.
//   5 else: pc_en=1, ifid_en=1, all other controls 0.
//  DRAIN: pc_en=0, ifid_en=0, idex_bubble=1. mem_busy still freezes. Go to HALTED on the edge
//   where the shadow ex/mem/wb are all invalid after the update. Latency is 4 cycles from HALT in
//   ID to halted=1 when there are no freezes.
//  HALTED: halted=1, pc_en=ifid_en=0, idex_bubble=1. Only reset exits this state.
//  stall_count increments by 1 per RUN cycle with pc_en=0 (freeze, hazard, or the halt cycle).
//   It holds at 2^CNT_W-1 once reached and does not increment in DRAIN or HALTED.
//  Reset mid-DRAIN or mid-freeze: returns to RUN and clears all state; no pending redirect is kept.
// TESTING
//  T1 FORWARDING=1: LD r2 then ADD r3,r2,r1 back-to-back -> exactly 1 cycle pc_en=0 with
//     idex_bubble=1; stall_count=1. The same pair with 1 independent instruction between -> 0 stalls.
//  T2 FORWARDING=0: ADD r1 then SUB using r1 -> 2 stall cycles. With 1 instruction between ->
//     1 stall. With 2 instructions between -> 0 stalls.
//  T3 ex_redirect pulse while the ID instruction has a load-use hazard -> ifid_flush=1,
//     idex_bubble=1, pc_en=1 that cycle; no stall the next cycle.
//  T4 mem_busy high 3 cycles with ex_redirect high throughout -> pipe_freeze=1 and pc_en=0 for
//     3 cycles; flush on the 4th; stall_count=3.
//  T5 HALT in ID with an empty pipe -> DRAIN; halted=1 exactly 4 cycles later. Afterwards
//     id_valid and ex_redirect are ignored and pc_en stays 0.
//  T6 rst=0 for 1 cycle during DRAIN -> forced output values during reset; RUN afterwards,
//     halted=0, stall_count=0. Force 2^CNT_W hazard cycles (CNT_W=4) -> count saturates at 15.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline sequencer for the 5-stage core: tracks in-flight writers in a shadow EX/MEM/WB
// pipe and drives PC / IF-ID / ID-EX enables, flush, freeze and halt drain.
module hazard_sequencer #(
  parameter int REG_ADDR_W = 3,
  parameter int FORWARDING = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic                  id_rs_use,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rt_use,
  input  logic                  id_reg_write,
  input  logic [REG_ADDR_W-1:0] id_wr_reg,
  input  logic                  id_mem_read,
  input  logic                  id_halt,
  input  logic                  ex_redirect,
  input  logic                  mem_busy,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  pipe_freeze,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_count
);

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic [REG_ADDR_W-1:0] rd;
    logic                  ld;
  } stage_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t state, state_nxt;
  stage_t ex_q, mem_q, wb_q, id_ent, ex_d;
  logic   match_ex, match_mem, hazard;
  logic   advance, stall_inc;

  assign match_ex  = ex_q.valid & ex_q.wr &
                     ((id_rs_use & (id_rs == ex_q.rd)) | (id_rt_use & (id_rt == ex_q.rd)));
  assign match_mem = mem_q.valid & mem_q.wr &
                     ((id_rs_use & (id_rs == mem_q.rd)) | (id_rt_use & (id_rt == mem_q.rd)));

  generate
    if (FORWARDING != 0) begin : g_fwd
      // Only a load in EX cannot be forwarded in time.
      assign hazard = id_valid & match_ex & ex_q.ld;
    end else begin : g_nofwd
      assign hazard = id_valid & (match_ex | match_mem);
    end
  endgenerate

  assign id_ent = '{valid: id_valid, wr: id_reg_write, rd: id_wr_reg, ld: id_mem_read};
  assign ex_d   = advance ? id_ent : '0;

  always_comb begin
    state_nxt   = state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    halted      = 1'b0;
    advance     = 1'b0;
    stall_inc   = 1'b0;
    if (!rst) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            pipe_freeze = 1'b1;
            stall_inc   = 1'b1;
          end else if (ex_redirect) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (hazard) begin
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
          end else if (id_valid && id_halt) begin
            advance     = 1'b1;
            stall_inc   = 1'b1;
            state_nxt   = DRAIN;
          end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            advance     = 1'b1;
          end
        end
        DRAIN: begin
          idex_bubble = 1'b1;
          if (mem_busy) pipe_freeze = 1'b1;
          // After this shift ex gets a bubble, mem gets ex, wb gets mem.
          else if (!ex_q.valid && !mem_q.valid) state_nxt = HALTED;
        end
        HALTED: begin
          halted      = 1'b1;
          idex_bubble = 1'b1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      if (!pipe_freeze) begin
        ex_q  <= ex_d;
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
      if (stall_inc && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  // WB writes through the register file, so it is tracked but never consulted for hazards.
  logic unused;
  assign unused = ^{wb_q, mem_q.ld, ex_q.ld, match_mem};

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: one forwarding instance (a) and one
// non-forwarding, 4-bit-counter instance (b) share the same stimulus.
module tb_hazard_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_use, id_rt_use, id_reg_write, id_mem_read, id_halt;
  logic [2:0] id_rs, id_rt, id_wr_reg;
  logic       ex_redirect, mem_busy;

  logic        pc_en_a, ifid_en_a, ifid_flush_a, idex_bubble_a, pipe_freeze_a, halted_a;
  logic [15:0] stall_count_a;
  logic        pc_en_b, ifid_en_b, ifid_flush_b, idex_bubble_b, pipe_freeze_b, halted_b;
  logic [3:0]  stall_count_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.REG_ADDR_W(3), .FORWARDING(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_use(id_rs_use),
    .id_rt(id_rt), .id_rt_use(id_rt_use), .id_reg_write(id_reg_write), .id_wr_reg(id_wr_reg),
    .id_mem_read(id_mem_read), .id_halt(id_halt), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_en(pc_en_a), .ifid_en(ifid_en_a), .ifid_flush(ifid_flush_a), .idex_bubble(idex_bubble_a),
    .pipe_freeze(pipe_freeze_a), .halted(halted_a), .stall_count(stall_count_a));

  hazard_sequencer #(.REG_ADDR_W(3), .FORWARDING(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_use(id_rs_use),
    .id_rt(id_rt), .id_rt_use(id_rt_use), .id_reg_write(id_reg_write), .id_wr_reg(id_wr_reg),
    .id_mem_read(id_mem_read), .id_halt(id_halt), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_en(pc_en_b), .ifid_en(ifid_en_b), .ifid_flush(ifid_flush_b), .idex_bubble(idex_bubble_b),
    .pipe_freeze(pipe_freeze_b), .halted(halted_b), .stall_count(stall_count_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_id(input logic v, input logic [2:0] rs, input logic rsu,
                        input logic [2:0] rt, input logic rtu, input logic rw,
                        input logic [2:0] wr, input logic ld, input logic hlt);
    id_valid = v;  id_rs = rs;  id_rs_use = rsu;  id_rt = rt;  id_rt_use = rtu;
    id_reg_write = rw;  id_wr_reg = wr;  id_mem_read = ld;  id_halt = hlt;
  endtask

  task automatic nop();
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;  ex_redirect = 1'b0;  mem_busy = 1'b0;
    nop();
    tick();
    rst = 1'b1;
  endtask

  // control vector order: {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze, halted}
  task automatic chk_a(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {pc_en_a, ifid_en_a, ifid_flush_a, idex_bubble_a, pipe_freeze_a, halted_a};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s ctl_a observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {pc_en_b, ifid_en_b, ifid_flush_b, idex_bubble_b, pipe_freeze_b, halted_b};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s ctl_b observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s count observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  localparam logic [5:0] C_RUN    = 6'b110000;
  localparam logic [5:0] C_STALL  = 6'b000100;
  localparam logic [5:0] C_FLUSH  = 6'b111100;
  localparam logic [5:0] C_FREEZE = 6'b000010;
  localparam logic [5:0] C_RESET  = 6'b001100;
  localparam logic [5:0] C_HALTID = 6'b000000;
  localparam logic [5:0] C_DRAIN  = 6'b000100;
  localparam logic [5:0] C_HALTED = 6'b000101;

  initial begin
    // reset state
    rst = 1'b0;  ex_redirect = 1'b0;  mem_busy = 1'b0;
    nop();
    tick(); tick();
    settle();
    chk_a("reset_ctl_a", C_RESET);
    chk_b("reset_ctl_b", C_RESET);
    chk_cnt("reset_cnt_a", stall_count_a, 16'd0);
    chk_cnt("reset_cnt_b", 16'(stall_count_b), 16'd0);
    rst = 1'b1;

    // T1: LD r2 ; ADD r3,r2,r1 back-to-back on the forwarding core
    do_reset();
    set_id(1, 3'd1, 1, 3'd0, 0, 1, 3'd2, 1, 0); settle(); chk_a("t1_ld", C_RUN); tick();
    set_id(1, 3'd2, 1, 3'd1, 1, 1, 3'd3, 0, 0); settle(); chk_a("t1_use_stall", C_STALL); tick();
    settle(); chk_a("t1_use_go", C_RUN);
    chk_cnt("t1_cnt", stall_count_a, 16'd1);
    tick();
    // same pair with one independent instruction between
    do_reset();
    set_id(1, 3'd1, 1, 3'd0, 0, 1, 3'd2, 1, 0); tick();
    set_id(1, 3'd5, 1, 3'd6, 1, 1, 3'd4, 0, 0); settle(); chk_a("t1_sep_or", C_RUN); tick();
    set_id(1, 3'd2, 1, 3'd1, 1, 1, 3'd3, 0, 0); settle(); chk_a("t1_sep_add", C_RUN); tick();
    settle(); chk_cnt("t1_sep_cnt", stall_count_a, 16'd0);

    // T2: no forwarding, ADD r1 ; SUB r4,r1,r5
    do_reset();
    set_id(1, 3'd2, 1, 3'd3, 1, 1, 3'd1, 0, 0); tick();
    set_id(1, 3'd1, 1, 3'd5, 1, 1, 3'd4, 0, 0); settle(); chk_b("t2_raw_ex", C_STALL); tick();
    settle(); chk_b("t2_raw_mem", C_STALL); tick();
    settle(); chk_b("t2_raw_go", C_RUN); tick();
    settle(); chk_cnt("t2_cnt2", 16'(stall_count_b), 16'd2);
    chk_cnt("t2_fwd_cnt0", stall_count_a, 16'd0);
    // one instruction between
    do_reset();
    set_id(1, 3'd2, 1, 3'd3, 1, 1, 3'd1, 0, 0); tick();
    set_id(1, 3'd2, 1, 3'd3, 1, 1, 3'd6, 0, 0); tick();
    set_id(1, 3'd1, 1, 3'd5, 1, 1, 3'd4, 0, 0); settle(); chk_b("t2_sep1_stall", C_STALL); tick();
    settle(); chk_b("t2_sep1_go", C_RUN); tick();
    settle(); chk_cnt("t2_cnt1", 16'(stall_count_b), 16'd1);
    // two instructions between
    do_reset();
    set_id(1, 3'd2, 1, 3'd3, 1, 1, 3'd1, 0, 0); tick();
    set_id(1, 3'd2, 1, 3'd3, 1, 1, 3'd6, 0, 0); tick();
    set_id(1, 3'd2, 1, 3'd3, 1, 1, 3'd7, 0, 0); tick();
    set_id(1, 3'd1, 1, 3'd5, 1, 1, 3'd4, 0, 0); settle(); chk_b("t2_sep2_go", C_RUN); tick();
    settle(); chk_cnt("t2_cnt0", 16'(stall_count_b), 16'd0);

    // T3: redirect while ID has a load-use hazard
    do_reset();
    set_id(1, 3'd1, 1, 3'd0, 0, 1, 3'd2, 1, 0); tick();
    set_id(1, 3'd2, 1, 3'd1, 1, 1, 3'd3, 0, 0); ex_redirect = 1'b1;
    settle(); chk_a("t3_flush", C_FLUSH); tick();
    ex_redirect = 1'b0;
    settle(); chk_a("t3_after", C_RUN);
    chk_cnt("t3_cnt", stall_count_a, 16'd0);

    // T4: mem_busy for 3 cycles with redirect pending throughout
    do_reset();
    set_id(1, 3'd5, 1, 3'd6, 1, 1, 3'd4, 0, 0);
    mem_busy = 1'b1;  ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle(); chk_a("t4_freeze", C_FREEZE); tick();
    end
    mem_busy = 1'b0;
    settle(); chk_a("t4_flush", C_FLUSH); tick();
    ex_redirect = 1'b0;
    settle(); chk_cnt("t4_cnt", stall_count_a, 16'd3);

    // T5: HALT with empty pipe
    do_reset();
    set_id(1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 1);
    settle(); chk_a("t5_halt_id", C_HALTID); tick();
    nop();
    for (int i = 1; i < 4; i++) begin
      settle(); chk_a("t5_drain", C_DRAIN); tick();
    end
    settle(); chk_a("t5_halted", C_HALTED);
    set_id(1, 3'd5, 1, 3'd6, 1, 1, 3'd4, 0, 0); ex_redirect = 1'b1;
    tick(); settle(); chk_a("t5_ignore", C_HALTED);
    chk_cnt("t5_cnt", stall_count_a, 16'd1);
    ex_redirect = 1'b0;

    // T6: reset mid-DRAIN (with mem_busy asserted during reset)
    do_reset();
    set_id(1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 1); tick();
    nop(); tick();
    settle(); chk_a("t6_in_drain", C_DRAIN);
    rst = 1'b0;  mem_busy = 1'b1;
    settle(); chk_a("t6_forced", C_RESET);
    tick();
    rst = 1'b1;  mem_busy = 1'b0;
    settle(); chk_a("t6_run", C_RUN);
    chk_cnt("t6_cnt_clr", stall_count_a, 16'd0);

    // counter saturation: ADD r1,r1,r1 repeated on the no-forward core, 2 stalls per 3 cycles
    do_reset();
    set_id(1, 3'd1, 1, 3'd1, 1, 1, 3'd1, 0, 0);
    for (int i = 0; i < 22; i++) tick();
    settle(); chk_cnt("t6_cnt14", 16'(stall_count_b), 16'd14);
    for (int i = 0; i < 18; i++) tick();
    settle(); chk_cnt("t6_sat15", 16'(stall_count_b), 16'd15);
    chk_cnt("t6_fwd_nostall", stall_count_a, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
